// File: rtl/image_pingpong_sender_if.sv
`default_nettype none
// ============================================================================
// Module   : image_pingpong_sender_if
// Brief    : 128-bit valid/ready word stream feeding the ping-pong image sender.
// Revision : 1.0  initial release
// ============================================================================
interface image_pingpong_sender_if;
    logic         s_valid;
    logic [127:0] s_data;
    logic         s_ready;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface
`default_nettype wire

// File: rtl/image_pingpong_sender.sv
`default_nettype none
// ============================================================================
// Module   : image_pingpong_sender
// Brief    : Ping-pong frame buffer loaded from a word stream, swapped on a
//            timestamped frame start, serving rgb for (cx,cy) with 2-cycle latency.
// Revision : 1.0  initial release
// ============================================================================
module image_pingpong_sender #(
    parameter int BIT_WIDTH  = 12,
    parameter int BIT_HEIGHT = 11,
    parameter int BUF_AW     = 12,
    parameter int MONO       = 0
) (
    input  logic                   rtio_clk,
    input  logic                   rtio_reset,
    image_pingpong_sender_if.slave s,
    input  logic [63:0]            counter,
    input  logic [BIT_WIDTH-1:0]   cx,
    input  logic [BIT_HEIGHT-1:0]  cy,
    input  logic [BIT_WIDTH-1:0]   frame_width,
    input  logic [BIT_HEIGHT-1:0]  frame_height,
    input  logic [23:0]            bg_color,
    output logic [23:0]            rgb,
    output logic                   active_buf,
    output logic                   armed,
    output logic                   swap_pulse,
    output logic                   load_error
);
    localparam int PPW   = (MONO != 0) ? 16 : 5;
    localparam int PIX_W = (MONO != 0) ? 8 : 24;
    localparam int DEPTH = 1 << BUF_AW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_ready;
    logic [63:0]   r_t;
    logic [15:0]   r_n;
    logic [16:0]   r_idx;
    logic          r_active;
    logic          r_armed;
    logic          r_swap;
    logic          r_err;

    logic          w_accept;
    logic          w_load_acc;
    logic          w_swap_go;
    logic [16:0]   w_next_idx;
    logic [16:0]   w_pidx [PPW];
    logic [PPW-1:0] w_wr;
    logic [PPW-1:0] w_oob;
    logic          w_oob_any;
    logic          w_unused_pad;

    assign s.s_ready  = r_ready;
    assign active_buf = r_active;
    assign armed      = r_armed;
    assign swap_pulse = r_swap;
    assign load_error = r_err;

    assign w_accept     = s.s_valid && r_ready;
    assign w_load_acc   = w_accept && (r_state == ST_LOAD);
    assign w_swap_go    = (r_state == ST_ARMED) && (counter >= r_t) && (cx == '0) && (cy == '0);
    assign w_next_idx   = r_idx + 17'(PPW);
    assign w_unused_pad = ^s.s_data;

    // Per-lane pixel index; lanes past N are dropped, lanes past the buffer flag an error
    always_comb begin
        w_oob_any = 1'b0;
        for (int k = 0; k < PPW; k++) begin
            w_pidx[k] = r_idx + 17'(k);
            w_wr[k]   = w_load_acc && (w_pidx[k] < {1'b0, r_n});
            w_oob[k]  = w_pidx[k] >= 17'(DEPTH);
            w_oob_any = w_oob_any | (w_wr[k] & w_oob[k]);
        end
    end

    always_ff @(posedge rtio_clk) begin
        if (rtio_reset) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b0;
            r_t      <= '0;
            r_n      <= '0;
            r_idx    <= '0;
            r_active <= 1'b0;
            r_armed  <= 1'b0;
            r_swap   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_swap <= 1'b0;
            if (w_oob_any) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_t   <= s.s_data[127:64];
                        r_n   <= s.s_data[63:48];
                        r_idx <= '0;
                        if (s.s_data[63:48] == 16'd0) begin
                            r_state <= ST_ARMED;
                            r_ready <= 1'b0;
                            r_armed <= 1'b1;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_load_acc) begin
                        r_idx <= w_next_idx;
                        if (w_next_idx >= {1'b0, r_n}) begin
                            r_state <= ST_ARMED;
                            r_ready <= 1'b0;
                            r_armed <= 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (w_swap_go) begin
                        r_active <= ~r_active;
                        r_swap   <= 1'b1;
                        r_armed  <= 1'b0;
                        r_ready  <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

    // Both buffers share one array; the MSB selects the buffer, writes always go to the back one
    logic [PIX_W-1:0] r_mem [2*DEPTH];

    always_ff @(posedge rtio_clk) begin
        for (int k = 0; k < PPW; k++) begin
            if (w_wr[k] && !w_oob[k]) begin
                r_mem[{~r_active, w_pidx[k][BUF_AW-1:0]}] <= s.s_data[k*PIX_W +: PIX_W];
            end
        end
    end

    logic              r_inside;
    logic [BUF_AW-1:0] r_addr;
    logic              r_rd_buf;
    logic [23:0]       r_rgb;
    logic              w_inside;
    logic [BUF_AW-1:0] w_addr;
    logic [PIX_W-1:0]  w_pix;
    logic [23:0]       w_pix_rgb;

    assign w_inside = (cx < frame_width) && (cy < frame_height);
    // Only the low BUF_AW bits of the linear address matter, so the product is formed at that width
    assign w_addr   = BUF_AW'(cy) * BUF_AW'(frame_width) + BUF_AW'(cx);
    assign w_pix    = r_mem[{r_rd_buf, r_addr}];
    assign rgb      = r_rgb;

    generate
        if (MONO != 0) begin : g_mono
            assign w_pix_rgb = {3{w_pix}};
        end else begin : g_rgb
            assign w_pix_rgb = w_pix;
        end
    endgenerate

    always_ff @(posedge rtio_clk) begin
        if (rtio_reset) begin
            r_inside <= 1'b0;
            r_addr   <= '0;
            r_rd_buf <= 1'b0;
            r_rgb    <= '0;
        end else begin
            r_inside <= w_inside;
            r_addr   <= w_addr;
            r_rd_buf <= r_active;
            r_rgb    <= r_inside ? w_pix_rgb : bg_color;
        end
    end
endmodule
`default_nettype wire
